// File: rtl/serv_cfu_pkg.sv
// Shared opcode constants, FSM state encoding and sizing helper for the CFU MAC unit.
package serv_cfu_pkg;

   localparam logic [2:0] OP_MUL = 3'b000;
   localparam logic [2:0] OP_MAC = 3'b001;
   localparam logic [2:0] OP_SQD = 3'b010;
   localparam logic [2:0] OP_CLR = 3'b011;
   localparam logic [2:0] OP_RDA = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_RESP = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/serv_cfu_mac_if.sv
// CFU request/response bundle between the core (master) and the MAC unit (slave).
interface serv_cfu_mac_if;

   logic        i_cfu_valid;
   logic [2:0]  i_cfu_funct3;
   logic [31:0] i_cfu_rs1;
   logic [31:0] i_cfu_rs2;
   logic        o_cfu_ready;
   logic [31:0] o_cfu_rd;
   logic        o_busy;

   modport master (
      output i_cfu_valid, i_cfu_funct3, i_cfu_rs1, i_cfu_rs2,
      input  o_cfu_ready, o_cfu_rd, o_busy
   );

   modport slave (
      input  i_cfu_valid, i_cfu_funct3, i_cfu_rs1, i_cfu_rs2,
      output o_cfu_ready, o_cfu_rd, o_busy
   );

endinterface

// File: rtl/serv_cfu_shmul.sv
// Shift-add multiplier retiring MUL_BITS multiplier bits per enabled cycle; low 32 product bits only.
module serv_cfu_shmul
   import serv_cfu_pkg::*;
#(
   parameter int MUL_BITS       = 1,
   parameter     RESET_STRATEGY = "MINI"
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_enable,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_product,
   output logic        o_done
);

   localparam int STEPS = 32 / MUL_BITS;
   localparam int CNT_W = clog2(STEPS);

   generate
      if (!(MUL_BITS == 1 || MUL_BITS == 2 || MUL_BITS == 4)) begin : g_badMulBits
         $error("serv_cfu_shmul: MUL_BITS must be 1, 2 or 4");
      end
   endgenerate

   logic [CNT_W-1:0] r_count;
   logic [31:0]      r_mcand, r_mplier, r_product;
   logic [31:0]      w_partial, w_sum;
   logic [31:0]      w_mcandNext, w_mplierNext, w_productNext;

   always_comb begin
      w_partial = '0;
      for (int k = 0; k < MUL_BITS; k++) begin
         if (r_mplier[k]) w_partial = w_partial + (r_mcand << k);
      end
      w_sum = r_product + w_partial;
   end

   always_comb begin
      w_mcandNext   = r_mcand;
      w_mplierNext  = r_mplier;
      w_productNext = r_product;
      if (i_start) begin
         w_mcandNext   = i_a;
         w_mplierNext  = i_b;
         w_productNext = '0;
      end else if (i_enable) begin
         w_mcandNext   = r_mcand << MUL_BITS;
         w_mplierNext  = r_mplier >> MUL_BITS;
         w_productNext = w_sum;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)      r_count <= '0;
      else if (i_start)  r_count <= '0;
      else if (i_enable) r_count <= r_count + 1'b1;
   end

   generate
      if (RESET_STRATEGY == "NONE") begin : g_noReset
         always_ff @(posedge i_clk) begin
            r_mcand   <= w_mcandNext;
            r_mplier  <= w_mplierNext;
            r_product <= w_productNext;
         end
      end else begin : g_miniReset
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_mcand   <= '0;
               r_mplier  <= '0;
               r_product <= '0;
            end else begin
               r_mcand   <= w_mcandNext;
               r_mplier  <= w_mplierNext;
               r_product <= w_productNext;
            end
         end
      end
   endgenerate

   // o_product is the running sum including this cycle's partial, so it is final while o_done is high
   assign o_product = w_sum;
   assign o_done    = i_enable && (r_count == CNT_W'(STEPS - 1));

endmodule

// File: rtl/serv_cfu_mac.sv
// CFU multiply / MAC / squared-difference unit: request FSM, accumulator and result register.
module serv_cfu_mac
   import serv_cfu_pkg::*;
#(
   parameter int MUL_BITS       = 1,
   parameter     RESET_STRATEGY = "MINI"
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   serv_cfu_mac_if.slave io_cfu
);

   state_t      r_state, w_stateNext;
   logic [2:0]  r_op;
   logic [31:0] r_acc, r_rd, w_accNext, w_rdNext;
   logic [31:0] w_diff, w_mulA, w_mulB, w_product;
   logic        w_isMulOp, w_accept, w_start, w_done;

   assign w_isMulOp = io_cfu.i_cfu_funct3 inside {OP_MUL, OP_MAC, OP_SQD};
   assign w_accept  = (r_state == ST_IDLE) && io_cfu.i_cfu_valid;
   assign w_start   = w_accept && w_isMulOp;
   assign w_diff    = io_cfu.i_cfu_rs1 - io_cfu.i_cfu_rs2;
   assign w_mulA    = (io_cfu.i_cfu_funct3 == OP_SQD) ? w_diff : io_cfu.i_cfu_rs1;
   assign w_mulB    = (io_cfu.i_cfu_funct3 == OP_SQD) ? w_diff : io_cfu.i_cfu_rs2;

   serv_cfu_shmul #(
      .MUL_BITS       (MUL_BITS),
      .RESET_STRATEGY (RESET_STRATEGY)
   ) u_shmul (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_start   (w_start),
      .i_enable  (r_state == ST_CALC),
      .i_a       (w_mulA),
      .i_b       (w_mulB),
      .o_product (w_product),
      .o_done    (w_done)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_op    <= OP_MUL;
      end else begin
         r_state <= w_stateNext;
         if (w_start) r_op <= io_cfu.i_cfu_funct3;
      end
   end

   // Valid low in CALC means the core abandoned the instruction, so no response is produced
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE: if (io_cfu.i_cfu_valid) w_stateNext = w_isMulOp ? ST_CALC : ST_RESP;
         ST_CALC: begin
            if (!io_cfu.i_cfu_valid) w_stateNext = ST_IDLE;
            else if (w_done)         w_stateNext = ST_RESP;
         end
         ST_RESP: w_stateNext = io_cfu.i_cfu_valid ? ST_HOLD : ST_IDLE;
         ST_HOLD: if (!io_cfu.i_cfu_valid) w_stateNext = ST_IDLE;
         default: w_stateNext = ST_IDLE;
      endcase
   end

   always_comb begin
      w_accNext = r_acc;
      w_rdNext  = r_rd;
      if (w_accept && !w_isMulOp) begin
         case (io_cfu.i_cfu_funct3)
            OP_CLR: begin
               w_rdNext  = r_acc;
               w_accNext = '0;
            end
            OP_RDA:  w_rdNext = r_acc;
            default: w_rdNext = '0;
         endcase
      end else if ((r_state == ST_CALC) && io_cfu.i_cfu_valid && w_done) begin
         if (r_op == OP_MUL) begin
            w_rdNext = w_product;
         end else begin
            w_accNext = r_acc + w_product;
            w_rdNext  = r_acc + w_product;
         end
      end
   end

   generate
      if (RESET_STRATEGY == "NONE") begin : g_noReset
         always_ff @(posedge i_clk) begin
            r_acc <= w_accNext;
            r_rd  <= w_rdNext;
         end
      end else begin : g_miniReset
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_acc <= '0;
               r_rd  <= '0;
            end else begin
               r_acc <= w_accNext;
               r_rd  <= w_rdNext;
            end
         end
      end
   endgenerate

   assign io_cfu.o_cfu_ready = (r_state == ST_RESP);
   assign io_cfu.o_busy      = (r_state == ST_CALC) || (r_state == ST_RESP);
   assign io_cfu.o_cfu_rd    = r_rd;

endmodule

// File: doc/serv_cfu_mac.md
Name: serv_cfu_mac

Overview:
- Multi-cycle custom function unit hanging off the core's CFU handshake. It consumes the level-held valid request issued while the core idles between stages, and returns a single-cycle ready pulse that makes the core request its RF write.
- Provides shift-add multiply, multiply-accumulate and squared-difference accumulate for SVM kernel evaluation.
- Holds a 32-bit accumulator.

Parameters:
- MUL_BITS, default 1: multiplier bits retired per CALC cycle. Legal values: 1, 2, 4. Any other value is a elaboration error.
- RESET_STRATEGY, default "MINI": "NONE" leaves the datapath registers (operands, product, accumulator, o_cfu_rd) unreset. Control state and o_cfu_ready are always reset.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cfu_valid  in  1  request from the core; held high until the core starts its stage-two count
- i_cfu_funct3  in  3  operation select
- i_cfu_rs1  in  32  operand A
- i_cfu_rs2  in  32  operand B
- o_cfu_ready  out  1  one-cycle completion pulse
- o_cfu_rd  out  32  result; stable from ready until the next acceptance
- o_busy  out  1  high in CALC and RESP

Behaviour:
- Reset (async assert, sync release): state=IDLE; o_cfu_ready=0; o_busy=0; counter=0. Unless RESET_STRATEGY is "NONE", o_cfu_rd=0, acc=0 and the operand/product registers are 0.
- Ops by funct3:
  - 000 MUL: rd = low32(rs1*rs2).
  - 001 MAC: acc = acc + low32(rs1*rs2); rd = new acc.
  - 010 SQD: d = rs1 - rs2 (mod 2^32); acc = acc + low32(d*d); rd = new acc.
  - 011 CLR: rd = old acc; acc = 0.
  - 100 RDA: rd = acc.
  - 101..111: rd = 0; acc unchanged.
- Arithmetic is mod 2^32 and sign-agnostic (only low product bits are used). No saturation; acc wraps silently.
- States: IDLE, CALC, RESP, HOLD.
- IDLE:
  - i_cfu_valid=1 with funct3 in {MUL, MAC, SQD}: latch multiplicand (rs1, or d for SQD), latch multiplier (rs2, or d for SQD) and op; clear product and counter; go to CALC.
  - i_cfu_valid=1 with any other op: compute rd/acc on that edge; go to RESP.
- CALC:
  - Each cycle: product += multiplicand * multiplier[MUL_BITS-1:0]; multiplicand <<= MUL_BITS; multiplier >>= MUL_BITS; counter++.
  - After 32/MUL_BITS cycles: write rd (and acc for MAC/SQD); go to RESP.
- RESP: o_cfu_ready=1 for exactly this one cycle; go to HOLD.
- HOLD: wait while i_cfu_valid=1. The core keeps valid high for several cycles after ready, until its RF becomes ready. No re-acceptance in HOLD. Go to IDLE when i_cfu_valid=0.
- Latency, counted from the edge that accepts valid in IDLE:
  - multiply ops: ready is high in cycle 32/MUL_BITS+1 (33 for MUL_BITS=1, 9 for MUL_BITS=4);
  - other ops: ready is high in cycle 1.
- Valid dropping in CALC (core aborted, e.g. reset or flush): abort to IDLE next cycle. No ready pulse; acc and o_cfu_rd unchanged.
- Valid dropping in RESP: ready still pulses; then go straight to IDLE.
- Back-to-back requests: a new request is accepted only in IDLE, so there is at least one idle cycle with valid low between requests.
- Operand inputs are don't-care outside the acceptance edge.
- Reset asserted mid-CALC: immediate return to the reset values above; no ready.

Decomposition:
- serv_cfu_pkg:
  - funct3 op localparams (OP_MUL, OP_MAC, OP_SQD, OP_CLR, OP_RDA);
  - state encoding (2-bit);
  - counter width function clog2(32/MUL_BITS).
- Sub-module serv_cfu_shmul: shift-add multiplier.
  - Inputs: start, a, b. Outputs: low32 product, done.
  - Parameterised by MUL_BITS.
  - Owns the product, shift registers and counter.
- Top level: FSM, accumulator, op decode and the o_cfu_rd register.

Test Plan:
- MUL_BITS=1, MUL rs1=0x0000_1234, rs2=0x0000_5678 -> ready pulse in cycle 33, rd=0x0626_0060, acc unchanged (0).
- MAC three times with (3,4), (0xFFFF_FFFF,2), (5,6) from acc=0 -> rd=12, then 10 (wrap), then 40; RDA then returns 40 with ready in cycle 1.
- SQD rs1=2, rs2=7 with acc=40 -> d=0xFFFF_FFFB, rd=65; CLR -> rd=65, a following RDA gives 0.
- Valid held high for 6 cycles after the ready pulse -> exactly one ready pulse, no second acceptance; a new request is accepted only after valid has been low for at least one cycle.
- Valid dropped at CALC cycle 10 of a MAC -> no ready, acc and rd unchanged; reset asserted at CALC cycle 5 -> o_busy=0, acc=0 immediately.
- MUL_BITS=4, MUL 0xFFFF_FFFF*0xFFFF_FFFF -> ready in cycle 9, rd=0x0000_0001; funct3=111 -> rd=0, ready in cycle 1.
